// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the MIPS-subset CPU: steps each instruction through
// IF/ID/EXE/MEM/WB and decodes datapath enables, mux selects and ALUOp from state/opcode/zero.
module mc_control_unit #(
   parameter int OPW = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   output logic [2:0]     state,
   output logic           PCWre,
   output logic [1:0]     PCSrc,
   output logic           IRWre,
   output logic           ALUSrcA,
   output logic [1:0]     ALUSrcB,
   output logic [2:0]     ALUOp,
   output logic           ExtSel,
   output logic           RegDst,
   output logic           RegWre,
   output logic           WrRegDSrc,
   output logic           mRD,
   output logic           mWR
);

   typedef enum logic [2:0] {
      S_IF      = 3'd0,
      S_ID      = 3'd1,
      S_EXE_AL  = 3'd2,
      S_WB_AL   = 3'd3,
      S_EXE_MEM = 3'd4,
      S_MEM     = 3'd5,
      S_WB_LD   = 3'd6,
      S_EXE_BR  = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      C_ARITH,
      C_SW,
      C_LW,
      C_BEQ,
      C_J,
      C_HALT,
      C_UNDEF
   } opclass_t;

   localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
   localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
   localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
   localparam logic [OPW-1:0] OP_OR   = 6'b010000;
   localparam logic [OPW-1:0] OP_AND  = 6'b010001;
   localparam logic [OPW-1:0] OP_ORI  = 6'b010010;
   localparam logic [OPW-1:0] OP_SLL  = 6'b011000;
   localparam logic [OPW-1:0] OP_SLT  = 6'b100110;
   localparam logic [OPW-1:0] OP_SW   = 6'b110000;
   localparam logic [OPW-1:0] OP_LW   = 6'b110001;
   localparam logic [OPW-1:0] OP_BEQ  = 6'b110100;
   localparam logic [OPW-1:0] OP_J    = 6'b111000;
   localparam logic [OPW-1:0] OP_HALT = 6'b111111;

   state_t   cur;
   opclass_t opClass;
   logic [2:0] aluCode;
   logic [1:0] aluSrcBSel;
   logic       aluSrcASel;
   logic       extSign;
   logic       rdDest;

   // Opcode decode: instruction class plus the ALU-stage controls of arithmetic ops
   always_comb begin
      opClass    = C_UNDEF;
      aluCode    = 3'b000;
      aluSrcBSel = 2'b00;
      aluSrcASel = 1'b0;
      extSign    = 1'b1;
      rdDest     = 1'b1;
      case (opcode)
         OP_ADD:  opClass = C_ARITH;
         OP_SUB: begin
            opClass = C_ARITH;
            aluCode = 3'b001;
         end
         OP_ADDI: begin
            opClass    = C_ARITH;
            aluSrcBSel = 2'b01;
            rdDest     = 1'b0;
         end
         OP_OR: begin
            opClass = C_ARITH;
            aluCode = 3'b101;
         end
         OP_AND: begin
            opClass = C_ARITH;
            aluCode = 3'b110;
         end
         OP_ORI: begin
            opClass    = C_ARITH;
            aluCode    = 3'b101;
            aluSrcBSel = 2'b01;
            extSign    = 1'b0;
            rdDest     = 1'b0;
         end
         OP_SLL: begin
            opClass    = C_ARITH;
            aluCode    = 3'b100;
            aluSrcBSel = 2'b10;
            aluSrcASel = 1'b1;
         end
         OP_SLT: begin
            opClass = C_ARITH;
            aluCode = 3'b010;
         end
         OP_SW:   opClass = C_SW;
         OP_LW:   opClass = C_LW;
         OP_BEQ:  opClass = C_BEQ;
         OP_J:    opClass = C_J;
         OP_HALT: opClass = C_HALT;
         default: opClass = C_UNDEF;
      endcase
   end

   // State register; halt parks in ID until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= S_IF;
      end else begin
         case (cur)
            S_IF: cur <= S_ID;
            S_ID: begin
               case (opClass)
                  C_ARITH:     cur <= S_EXE_AL;
                  C_SW, C_LW:  cur <= S_EXE_MEM;
                  C_BEQ:       cur <= S_EXE_BR;
                  C_HALT:      cur <= S_ID;
                  default:     cur <= S_IF;
               endcase
            end
            S_EXE_AL:  cur <= S_WB_AL;
            S_WB_AL:   cur <= S_IF;
            S_EXE_MEM: cur <= S_MEM;
            S_MEM:     cur <= (opClass == C_LW) ? S_WB_LD : S_IF;
            S_WB_LD:   cur <= S_IF;
            S_EXE_BR:  cur <= S_IF;
            default:   cur <= S_IF;
         endcase
      end
   end

   assign state = cur;

   // Output decode; reset gates every enable so nothing is written while rst is high
   always_comb begin
      PCWre     = 1'b0;
      PCSrc     = 2'b00;
      IRWre     = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ALUOp     = 3'b000;
      ExtSel    = 1'b0;
      RegDst    = 1'b0;
      RegWre    = 1'b0;
      WrRegDSrc = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      if (!rst) begin
         case (cur)
            S_IF: IRWre = 1'b1;
            S_ID: begin
               if (opClass == C_J) begin
                  PCWre = 1'b1;
                  PCSrc = 2'b11;
               end else if (opClass == C_UNDEF) begin
                  PCWre = 1'b1;
               end
            end
            S_EXE_AL, S_WB_AL: begin
               if (opClass == C_ARITH) begin
                  ALUOp   = aluCode;
                  ALUSrcA = aluSrcASel;
                  ALUSrcB = aluSrcBSel;
                  ExtSel  = extSign;
                  RegDst  = rdDest;
                  if (cur == S_WB_AL) begin
                     RegWre = 1'b1;
                     PCWre  = 1'b1;
                  end
               end
            end
            S_EXE_MEM: begin
               ALUSrcB = 2'b01;
               ExtSel  = 1'b1;
            end
            S_MEM: begin
               if (opClass == C_LW) begin
                  mRD = 1'b1;
               end else if (opClass == C_SW) begin
                  mWR   = 1'b1;
                  PCWre = 1'b1;
               end
            end
            S_WB_LD: begin
               RegWre    = 1'b1;
               WrRegDSrc = 1'b1;
               PCWre     = 1'b1;
            end
            S_EXE_BR: begin
               ALUOp  = 3'b001;
               ExtSel = 1'b1;
               PCWre  = 1'b1;
               PCSrc  = zero ? 2'b01 : 2'b00;
            end
            default: ;
         endcase
      end
   end

endmodule
